// File: rtl/uart_rx_deframer_if.sv
// Receive-side result bus of the UART deframer: recovered byte, status flags
// and the frame-in-progress indicator.
interface uart_rx_deframer_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       frame_error;
    logic       busy;

    // Deframer drives the bus
    modport master (
        output data_out,
        output data_valid,
        output parity_error,
        output frame_error,
        output busy
    );

    // Receive buffer consumes the bus
    modport slave (
        input data_out,
        input data_valid,
        input parity_error,
        input frame_error,
        input busy
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: oversampled start detection, 7/8 data bits LSB-first,
// optional odd/even parity, 1 or 2 stop bits, break-safe return to idle.
module uart_rx_deframer #(
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_tick,
    input  logic                  rx,
    input  logic                  dL,
    input  logic [1:0]            p,
    input  logic                  s,
    uart_rx_deframer_if.master    out_if
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        DONE,
        WAIT_IDLE
    } state_t;

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OVERSAMPLE - 1);

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_meta_d;
    logic             rx_s_q, rx_s_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             dl_q, dl_d;
    logic [1:0]       p_q, p_d;
    logic             s_q, s_d;
    logic             par_err_q, par_err_d;
    logic             frm_err_q, frm_err_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             parity_error_q, parity_error_d;
    logic             frame_error_q, frame_error_d;

    logic             par_en;
    logic             tick_end;
    logic [2:0]       last_bit;
    logic             par_xor;

    // Parity is active only for the odd (01) and even (10) codes
    assign par_en   = p_q[0] ^ p_q[1];
    assign tick_end = (tick_cnt_q == FULL_CNT);
    assign last_bit = dl_q ? 3'd7 : 3'd6;
    // Bit 7 is cleared at frame start, so in 7-bit mode it does not disturb the XOR
    assign par_xor  = ^shift_q ^ rx_s_q;

    // Next-state, sampling and output-load logic
    always_comb begin
        rx_meta_d      = rx;
        rx_s_d         = rx_meta_q;
        state_d        = state_q;
        tick_cnt_d     = tick_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        dl_d           = dl_q;
        p_d            = p_q;
        s_d            = s_q;
        par_err_d      = par_err_q;
        frm_err_d      = frm_err_q;
        data_out_d     = data_out_q;
        data_valid_d   = 1'b0;
        parity_error_d = parity_error_q;
        frame_error_d  = frame_error_q;

        unique case (state_q)
            IDLE: begin
                if (s_tick && !rx_s_q) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    shift_d    = '0;
                    par_err_d  = 1'b0;
                    frm_err_d  = 1'b0;
                    dl_d       = dL;
                    p_d        = p;
                    s_d        = s;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_cnt_q == HALF_CNT) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        // Line back high at mid start bit means a glitch, not a frame
                        state_d    = rx_s_q ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_end) begin
                        tick_cnt_d         = '0;
                        shift_d[bit_cnt_q] = rx_s_q;
                        if (bit_cnt_q == last_bit) begin
                            state_d = par_en ? PARITY : STOP1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (tick_end) begin
                        tick_cnt_d = '0;
                        // Odd: total XOR must be 1; even: total XOR must be 0
                        par_err_d  = p_q[0] ? ~par_xor : par_xor;
                        state_d    = STOP1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            STOP1, STOP2: begin
                if (s_tick) begin
                    if (tick_end) begin
                        tick_cnt_d = '0;
                        if (!rx_s_q) frm_err_d = 1'b1;
                        state_d = (state_q == STOP1 && s_q) ? STOP2 : DONE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                data_out_d     = shift_q;
                parity_error_d = par_err_q;
                frame_error_d  = frm_err_q;
                data_valid_d   = 1'b1;
                // A line still low after a bad stop is a break: wait for it to release
                state_d        = (frm_err_q && !rx_s_q) ? WAIT_IDLE : IDLE;
            end
            WAIT_IDLE: begin
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, synchronizer and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            rx_meta_q      <= 1'b1;
            rx_s_q         <= 1'b1;
            tick_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            dl_q           <= 1'b0;
            p_q            <= 2'b00;
            s_q            <= 1'b0;
            par_err_q      <= 1'b0;
            frm_err_q      <= 1'b0;
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            rx_meta_q      <= rx_meta_d;
            rx_s_q         <= rx_s_d;
            tick_cnt_q     <= tick_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            dl_q           <= dl_d;
            p_q            <= p_d;
            s_q            <= s_d;
            par_err_q      <= par_err_d;
            frm_err_q      <= frm_err_d;
            data_out_q     <= data_out_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            frame_error_q  <= frame_error_d;
        end
    end

    assign out_if.data_out     = data_out_q;
    assign out_if.data_valid   = data_valid_q;
    assign out_if.parity_error = parity_error_q;
    assign out_if.frame_error  = frame_error_q;
    assign out_if.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed + randomized bench for uart_rx_deframer. Frames are built bit by bit
// from the UART frame rules; expected results come from a frame-level model.
module tb_uart_rx_deframer;

    localparam int OS = 16;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       s_tick = 1'b0;
    logic       rx     = 1'b1;
    logic       dl     = 1'b1;
    logic [1:0] p      = 2'b00;
    logic       cfg_s  = 1'b0;

    uart_rx_deframer_if u_if ();

    uart_rx_deframer #(.OVERSAMPLE(OS), .CNT_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .s_tick (s_tick),
        .rx     (rx),
        .dL     (dl),
        .p      (p),
        .s      (cfg_s),
        .out_if (u_if.master)
    );

    always #5 clk = ~clk;

    // s_tick: one clk in three, changed on the falling edge
    initial begin
        int tc;
        tc = 0;
        forever begin
            @(negedge clk);
            s_tick = (tc == 0);
            tc = (tc == 2) ? 0 : tc + 1;
        end
    end

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    rec_t got_q[$];
    int   dv_cnt   = 0;
    int   checks   = 0;
    int   failures = 0;

    // Capture every data_valid pulse with the values presented alongside it
    always @(negedge clk) begin
        if (u_if.data_valid === 1'b1) begin
            got_q.push_back({u_if.data_out, u_if.parity_error, u_if.frame_error});
            dv_cnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!s_tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_ticks(OS);
    endtask

    task automatic idle_bits(input int n);
        repeat (n) send_bit(1'b1);
    endtask

    // Correct parity bit for the active data bits
    function automatic logic good_par(input logic [7:0] d, input logic dl_, input logic [1:0] pp);
        int ones;
        ones = $countones(dl_ ? d : (d & 8'h7F));
        return (pp == 2'b10) ? logic'(ones % 2) : logic'(1 - ones % 2);
    endfunction

    // Frame-level expectation from the received line bits
    function automatic rec_t model(input logic [7:0] d, input logic dl_, input logic [1:0] pp,
                                   input logic s_, input logic pb, input logic [1:0] stops);
        rec_t r;
        int   tot;
        r.d  = dl_ ? d : {1'b0, d[6:0]};
        tot  = $countones(r.d) + int'(pb);
        r.pe = (pp == 2'b01) ? (tot % 2 == 0) : (pp == 2'b10) ? (tot % 2 == 1) : 1'b0;
        r.fe = !stops[0] || (s_ && !stops[1]);
        return r;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic dl_, input logic [1:0] pp,
                              input logic s_, input logic pflip, input logic [1:0] stops,
                              input logic [1:0] p_mid, output rec_t exp);
        logic pb;
        dl    = dl_;
        p     = pp;
        cfg_s = s_;
        pb    = good_par(d, dl_, pp) ^ pflip;
        exp   = model(d, dl_, pp, s_, pb, stops);
        send_bit(1'b0);
        p = p_mid;
        for (int i = 0; i < (dl_ ? 8 : 7); i++) send_bit(d[i]);
        if (pp == 2'b01 || pp == 2'b10) send_bit(pb);
        send_bit(stops[0]);
        if (s_) send_bit(stops[1]);
    endtask

    task automatic expect_frame(input string tag, input rec_t exp);
        int   n;
        rec_t g;
        n = 0;
        while (got_q.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(got_q.size() > 0), 32'd1);
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            check({tag, "_data"}, 32'(g.d), 32'(exp.d));
            check({tag, "_perr"}, 32'(g.pe), 32'(exp.pe));
            check({tag, "_ferr"}, 32'(g.fe), 32'(exp.fe));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_data"}, 32'(u_if.data_out), 32'd0);
        check({tag, "_dv"},   32'(u_if.data_valid), 32'd0);
        check({tag, "_perr"}, 32'(u_if.parity_error), 32'd0);
        check({tag, "_ferr"}, 32'(u_if.frame_error), 32'd0);
        check({tag, "_busy"}, 32'(u_if.busy), 32'd0);
    endtask

    rec_t e, e2;
    int   dv0;

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        idle_bits(2);

        // 0xAB, 8 bits, even parity, one stop
        dv0 = dv_cnt;
        send_frame(8'hAB, 1'b1, 2'b10, 1'b0, 1'b0, 2'b11, 2'b10, e);
        expect_frame("ab_even", e);
        check("ab_pulses", 32'(dv_cnt - dv0), 32'd1);
        idle_bits(1);
        check("ab_idle_busy", 32'(u_if.busy), 32'd0);

        // 0x2B, 7 bits, odd parity, two stops; then parity bit flipped
        send_frame(8'h2B, 1'b0, 2'b01, 1'b1, 1'b0, 2'b11, 2'b01, e);
        expect_frame("2b_odd", e);
        idle_bits(1);
        send_frame(8'h2B, 1'b0, 2'b01, 1'b1, 1'b1, 2'b11, 2'b01, e);
        expect_frame("2b_odd_bad", e);
        check("2b_bad_perr_set", 32'(u_if.parity_error), 32'd1);
        idle_bits(1);

        // 0x6D, no parity, stop bit low -> frame error, line held low
        send_frame(8'h6D, 1'b1, 2'b00, 1'b0, 1'b0, 2'b10, 2'b00, e);
        expect_frame("6d_ferr", e);
        check("6d_busy_low_line", 32'(u_if.busy), 32'd1);
        idle_bits(1);
        check("6d_busy_released", 32'(u_if.busy), 32'd0);

        // Glitch: low for 3 ticks only
        dl = 1'b1; p = 2'b00; cfg_s = 1'b0;
        dv0 = dv_cnt;
        rx = 1'b0;
        wait_ticks(3);
        check("glitch_busy_hi", 32'(u_if.busy), 32'd1);
        rx = 1'b1;
        wait_ticks(OS);
        check("glitch_busy_lo", 32'(u_if.busy), 32'd0);
        check("glitch_no_dv", 32'(dv_cnt - dv0), 32'd0);

        // Break: line low for 30 bit periods -> exactly one errored frame
        dv0 = dv_cnt;
        rx = 1'b0;
        wait_ticks(30 * OS);
        check("break_pulses", 32'(dv_cnt - dv0), 32'd1);
        e = model(8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00);
        expect_frame("break", e);
        check("break_busy", 32'(u_if.busy), 32'd1);
        idle_bits(1);
        check("break_release_busy", 32'(u_if.busy), 32'd0);
        check("break_release_pulses", 32'(dv_cnt - dv0), 32'd1);
        send_frame(8'h55, 1'b1, 2'b10, 1'b0, 1'b0, 2'b11, 2'b10, e);
        expect_frame("after_break_55", e);
        idle_bits(1);

        // Back-to-back 0xFF, 0x00 odd parity; p changed mid frame 1
        dv0 = dv_cnt;
        send_frame(8'hFF, 1'b1, 2'b01, 1'b0, 1'b0, 2'b11, 2'b10, e);
        send_frame(8'h00, 1'b1, 2'b01, 1'b0, 1'b0, 2'b11, 2'b01, e2);
        expect_frame("b2b_ff", e);
        expect_frame("b2b_00", e2);
        check("b2b_pulses", 32'(dv_cnt - dv0), 32'd2);
        idle_bits(1);

        // Reset during DATA of 0xA5 aborts the frame and clears outputs
        send_frame(8'hC3, 1'b1, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, e);
        expect_frame("pre_rst_c3", e);
        idle_bits(1);
        dl = 1'b1; p = 2'b00; cfg_s = 1'b0;
        dv0 = dv_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero_outputs("mid_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        idle_bits(2);
        check("mid_rst_no_dv", 32'(dv_cnt - dv0), 32'd0);
        send_frame(8'h3C, 1'b1, 2'b10, 1'b1, 1'b0, 2'b11, 2'b10, e);
        expect_frame("post_rst_3c", e);
        idle_bits(1);

        // Randomized frames, configs, parity corruption and stop corruption
        for (int k = 0; k < 20; k++) begin
            logic [7:0] rd;
            logic       rdl, rs, rflip;
            logic [1:0] rp, rstops, rpm;
            rd     = 8'($urandom);
            rdl    = 1'($urandom);
            rp     = 2'($urandom_range(0, 3));
            rs     = 1'($urandom);
            rflip  = ($urandom_range(0, 3) == 0);
            rstops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            rpm    = 2'($urandom_range(0, 3));
            send_frame(rd, rdl, rp, rs, rflip, rstops, rpm, e);
            expect_frame($sformatf("rand%0d", k), e);
            idle_bits(e.fe ? 1 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 1)));
        end

        idle_bits(1);
        check("final_no_extra_dv", 32'(got_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
